// File: rtl/boot_pkg.sv
// Shared types and sizes for the boot loader: FSM state encoding, bus widths
// and the additive checksum step.
package boot_pkg;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 256;
   localparam int CNT_W     = 9;

   typedef enum logic [2:0] {
      LOAD,
      WR_HI,
      WR_LO,
      VRD_HI,
      VRD_LO,
      VCHK,
      RUN,
      HALT
   } state_t;

   function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] val);
      return acc + val;
   endfunction

endpackage

// File: rtl/boot_bus_mux.sv
// Memory bus ownership switch: ctrl drives mem while sel is high, the loader
// drives it otherwise. Purely combinational so the handover lands on one edge.
module boot_bus_mux
   import boot_pkg::*;
(
   input  logic              sel,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_data,
   input  logic              ldr_clock,
   input  logic              ldr_write,
   input  logic [ADDR_W-1:0] ctrl_addr,
   input  logic [DATA_W-1:0] ctrl_to_mem,
   input  logic              ctrl_mem_clock,
   input  logic              ctrl_mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_to,
   output logic              mem_clock,
   output logic              mem_write
);

   assign mem_addr  = sel ? ctrl_addr      : ldr_addr;
   assign mem_to    = sel ? ctrl_to_mem    : ldr_data;
   assign mem_clock = sel ? ctrl_mem_clock : ldr_clock;
   assign mem_write = sel ? ctrl_mem_write : ldr_write;

endmodule

// File: rtl/boot_loader.sv
// Streams a program image into mem from address 0, optionally re-reads it to
// check an 8-bit additive checksum, then hands the memory bus to ctrl.
module boot_loader
   import boot_pkg::*;
#(
   parameter bit VERIFY = 1'b1
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] ctrl_addr,
   input  logic [DATA_W-1:0] ctrl_to_mem,
   input  logic              ctrl_mem_clock,
   input  logic              ctrl_mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_to,
   input  logic [DATA_W-1:0] mem_from,
   output logic              mem_clock,
   output logic              mem_write,
   output logic              ctrl_run,
   output logic [CNT_W-1:0]  load_count,
   output logic              load_error,
   output logic              done
);

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  waddr, vaddr, ldr_addr;
   logic [DATA_W-1:0]  wdata, wsum, vsum, vsum_nxt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               last_q, err_q, ldr_clock, ldr_write, verify_end;

   assign cnt_inc    = load_count + 1'b1;
   assign vsum_nxt   = csum_add(vsum, mem_from);
   assign verify_end = ({1'b0, vaddr} + 1'b1) == load_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= LOAD;
         waddr      <= '0;
         vaddr      <= '0;
         wdata      <= '0;
         wsum       <= '0;
         vsum       <= '0;
         load_count <= '0;
         last_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            LOAD: if (in_valid) begin
               wdata  <= in_data;
               wsum   <= csum_add(wsum, in_data);
               last_q <= in_last;
            end
            WR_LO: begin
               waddr      <= waddr + 1'b1;
               load_count <= cnt_inc;
               vaddr      <= '0;
               vsum       <= '0;
            end
            VCHK: begin
               vsum  <= vsum_nxt;
               vaddr <= vaddr + 1'b1;
               if (state_nxt == HALT) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // The 256th byte ends the load whether or not it carries in_last.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (in_valid) state_nxt = WR_HI;
         WR_HI:   state_nxt = WR_LO;
         WR_LO: begin
            if (last_q || cnt_inc == CNT_W'(MEM_DEPTH))
               state_nxt = VERIFY ? VRD_HI : RUN;
            else
               state_nxt = LOAD;
         end
         VRD_HI:  state_nxt = VRD_LO;
         VRD_LO:  state_nxt = VCHK;
         VCHK: begin
            if (verify_end)
               state_nxt = (vsum_nxt == wsum) ? RUN : HALT;
            else
               state_nxt = VRD_HI;
         end
         default: state_nxt = state;
      endcase
   end

   always_comb begin
      ldr_clock = (state == WR_HI) || (state == VRD_HI);
      ldr_write = (state == WR_HI) || (state == WR_LO);
      ldr_addr  = waddr;
      if (state == VRD_HI || state == VRD_LO || state == VCHK) ldr_addr = vaddr;
   end

   assign in_ready   = (state == LOAD);
   assign ctrl_run   = (state == RUN);
   assign done       = (state == RUN) || (state == HALT);
   assign load_error = err_q;

   boot_bus_mux u_bus_mux (
      .sel            (ctrl_run),
      .ldr_addr       (ldr_addr),
      .ldr_data       (wdata),
      .ldr_clock      (ldr_clock),
      .ldr_write      (ldr_write),
      .ctrl_addr      (ctrl_addr),
      .ctrl_to_mem    (ctrl_to_mem),
      .ctrl_mem_clock (ctrl_mem_clock),
      .ctrl_mem_write (ctrl_mem_write),
      .mem_addr       (mem_addr),
      .mem_to         (mem_to),
      .mem_clock      (mem_clock),
      .mem_write      (mem_write)
   );

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: one verifying and one non-verifying instance share the
// input stream; each has its own memory model and is checked against expected images.
module tb_boot_loader;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0, in_last = 1'b0;
   logic [7:0] ctrl_addr = '0, ctrl_to_mem = '0;
   logic       ctrl_mem_clock = 1'b0, ctrl_mem_write = 1'b0;

   logic       in_ready1, mem_clock1, mem_write1, ctrl_run1, load_error1, done1;
   logic [7:0] mem_addr1, mem_to1;
   logic [7:0] mem_from1 = '0;
   logic [8:0] load_count1;
   logic       in_ready0, mem_clock0, mem_write0, ctrl_run0, load_error0, done0;
   logic [7:0] mem_addr0, mem_to0;
   logic [7:0] mem_from0 = '0;
   logic [8:0] load_count0;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int corrupt_addr = -1;
   logic [7:0] mem1 [256];
   logic [7:0] mem0 [256];
   logic pclk1 = 1'b0, pclk0 = 1'b0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   boot_loader #(.VERIFY(1'b1)) u_v1 (
      .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready1), .ctrl_addr(ctrl_addr),
      .ctrl_to_mem(ctrl_to_mem), .ctrl_mem_clock(ctrl_mem_clock),
      .ctrl_mem_write(ctrl_mem_write), .mem_addr(mem_addr1), .mem_to(mem_to1),
      .mem_from(mem_from1), .mem_clock(mem_clock1), .mem_write(mem_write1),
      .ctrl_run(ctrl_run1), .load_count(load_count1), .load_error(load_error1),
      .done(done1));

   boot_loader #(.VERIFY(1'b0)) u_v0 (
      .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready0), .ctrl_addr(ctrl_addr),
      .ctrl_to_mem(ctrl_to_mem), .ctrl_mem_clock(ctrl_mem_clock),
      .ctrl_mem_write(ctrl_mem_write), .mem_addr(mem_addr0), .mem_to(mem_to0),
      .mem_from(mem_from0), .mem_clock(mem_clock0), .mem_write(mem_write0),
      .ctrl_run(ctrl_run0), .load_count(load_count0), .load_error(load_error0),
      .done(done0));

   // Memories act on a rising strobe, detected mid-cycle; mem1 can corrupt one read address.
   always @(negedge clock) begin
      if (mem_clock1 && !pclk1) begin
         if (mem_write1) mem1[mem_addr1] <= mem_to1;
         else mem_from1 <= (int'(mem_addr1) == corrupt_addr) ? ~mem1[mem_addr1] : mem1[mem_addr1];
      end
      if (mem_clock0 && !pclk0) begin
         if (mem_write0) mem0[mem_addr0] <= mem_to0;
         else mem_from0 <= mem0[mem_addr0];
      end
      pclk1 <= mem_clock1;
      pclk0 <= mem_clock0;
   end

   task automatic apply_reset();
      in_valid = 0; in_last = 0; in_data = 0;
      ctrl_addr = 0; ctrl_to_mem = 0; ctrl_mem_clock = 0; ctrl_mem_write = 0;
      @(negedge clock); reset_n = 0;
      repeat (2) @(negedge clock);
      reset_n = 1;
   endtask

   // Offers bytes only while in_ready1 is seen; junk with in_valid while not ready.
   task automatic send_stream(input logic [7:0] b [$], input bit with_last,
                              input int gap_pct, output int first_acc);
      int i = 0;
      int guard = 0;
      first_acc = -1;
      while (i < b.size() && guard < 3000) begin
         @(posedge clock); #1;
         guard++;
         if (in_ready1 && int'($urandom_range(0, 99)) >= gap_pct) begin
            in_valid = 1; in_data = b[i];
            in_last = with_last && (i == b.size() - 1);
            if (i == 0) first_acc = cyc;
            i++;
         end else if (!in_ready1) begin
            in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
            in_last = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 0; in_last = 0;
         end
      end
      if (i < b.size()) begin
         n_cmp++; n_bad++;
         $display("FAIL send_stream: accepted %0d bytes, required %0d", i, b.size());
      end
      @(posedge clock); #1;
      in_valid = 0; in_last = 0;
   endtask

   task automatic wait_done(output int run1, output int run0);
      run1 = -1; run0 = -1;
      for (int k = 0; k < 4000; k++) begin
         if (ctrl_run1 && run1 < 0) run1 = cyc;
         if (ctrl_run0 && run0 < 0) run0 = cyc;
         if (done1 && done0) return;
         @(posedge clock); #1;
      end
      n_cmp++; n_bad++;
      $display("FAIL wait_done: done1=%0b done0=%0b, required 1/1 within 4000 cycles", done1, done0);
   endtask

   task automatic test_reset();
      @(negedge clock); reset_n = 0; #1;
      n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready1); end
      n_cmp++; if (mem_clock1 !== 1'b0) begin n_bad++; $display("FAIL rst_mem_clock: got %b want 0", mem_clock1); end
      n_cmp++; if (mem_write1 !== 1'b0) begin n_bad++; $display("FAIL rst_mem_write: got %b want 0", mem_write1); end
      n_cmp++; if (mem_addr1 !== 8'h00) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 00", mem_addr1); end
      n_cmp++; if (mem_to1 !== 8'h00) begin n_bad++; $display("FAIL rst_mem_to: got %h want 00", mem_to1); end
      n_cmp++; if (ctrl_run1 !== 1'b0) begin n_bad++; $display("FAIL rst_ctrl_run: got %b want 0", ctrl_run1); end
      n_cmp++; if (load_count1 !== 9'd0) begin n_bad++; $display("FAIL rst_load_count: got %0d want 0", load_count1); end
      n_cmp++; if (load_error1 !== 1'b0) begin n_bad++; $display("FAIL rst_load_error: got %b want 0", load_error1); end
      n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done1); end
      n_cmp++; if ({in_ready0, ctrl_run0, done0} !== 3'b100) begin n_bad++; $display("FAIL rst_v0: got %b want 100", {in_ready0, ctrl_run0, done0}); end
      @(negedge clock); reset_n = 1;
   endtask

   task automatic test_directed4();
      logic [7:0] b [$];
      int fa, r1, r0;
      apply_reset();
      b = {8'h11, 8'h22, 8'h33, 8'h44};
      send_stream(b, 1, 0, fa);
      wait_done(r1, r0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (mem1[i] !== b[i]) begin n_bad++; $display("FAIL d4_mem1[%0d]: got %h want %h", i, mem1[i], b[i]); end
      end
      n_cmp++; if (load_count1 !== 9'd4) begin n_bad++; $display("FAIL d4_count: got %0d want 4", load_count1); end
      n_cmp++; if (r1 - fa !== 24) begin n_bad++; $display("FAIL d4_run_latency_v1: got %0d want 24", r1 - fa); end
      n_cmp++; if (r0 - fa !== 12) begin n_bad++; $display("FAIL d4_run_latency_v0: got %0d want 12", r0 - fa); end
      n_cmp++; if (load_error1 !== 1'b0) begin n_bad++; $display("FAIL d4_error: got %b want 0", load_error1); end
      n_cmp++; if (mem0[3] !== 8'h44) begin n_bad++; $display("FAIL d4_mem0[3]: got %h want 44", mem0[3]); end
   endtask

   task automatic test_random_gaps();
      logic [7:0] b [$];
      int fa, r1, r0, len, bad;
      for (int it = 0; it < 3; it++) begin
         apply_reset();
         b = {};
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) b.push_back(8'($urandom));
         send_stream(b, 1, 30, fa);
         wait_done(r1, r0);
         bad = 0;
         for (int i = 0; i < len; i++) if (mem1[i] !== b[i] || mem0[i] !== b[i]) bad++;
         n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rnd_mem: %0d of %0d bytes wrong, want 0", bad, len); end
         n_cmp++; if (load_count1 !== 9'(len)) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", load_count1, len); end
         n_cmp++; if ({ctrl_run1, load_error1, ctrl_run0} !== 3'b101) begin n_bad++; $display("FAIL rnd_status: got %b want 101", {ctrl_run1, load_error1, ctrl_run0}); end
      end
   endtask

   task automatic test_full256();
      logic [7:0] b [$];
      int fa, r1, r0, bad, extra;
      apply_reset();
      for (int i = 0; i < 256; i++) b.push_back(8'($urandom));
      send_stream(b, 0, 10, fa);
      in_valid = 1; in_data = 8'($urandom); in_last = 0;
      wait_done(r1, r0);
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         if (in_ready1 || in_ready0) extra++;
         @(posedge clock); #1;
      end
      in_valid = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem1[i] !== b[i]) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL f256_mem: %0d bytes wrong, want 0", bad); end
      n_cmp++; if (load_count1 !== 9'd256 || load_count0 !== 9'd256) begin n_bad++; $display("FAIL f256_count: got %0d/%0d want 256", load_count1, load_count0); end
      n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL f256_no_257th: ready cycles %0d want 0", extra); end
      n_cmp++; if ({done1, ctrl_run1, load_error1} !== 3'b110) begin n_bad++; $display("FAIL f256_status: got %b want 110", {done1, ctrl_run1, load_error1}); end
   endtask

   task automatic test_corrupt();
      logic [7:0] b [$];
      int fa, r1, r0;
      apply_reset();
      corrupt_addr = 2;
      for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
      send_stream(b, 1, 0, fa);
      wait_done(r1, r0);
      n_cmp++; if ({load_error1, done1, ctrl_run1, in_ready1} !== 4'b1100) begin n_bad++; $display("FAIL cor_status: got %b want 1100", {load_error1, done1, ctrl_run1, in_ready1}); end
      n_cmp++; if ({ctrl_run0, load_error0} !== 2'b10) begin n_bad++; $display("FAIL cor_v0: got %b want 10", {ctrl_run0, load_error0}); end
      ctrl_addr = 8'hEE; ctrl_mem_clock = 1; #1;
      n_cmp++; if (mem_clock1 !== 1'b0 || mem_addr1 === 8'hEE) begin n_bad++; $display("FAIL cor_bus_held: clk %b addr %h want 0/not EE", mem_clock1, mem_addr1); end
      ctrl_mem_clock = 0;
      repeat (10) @(posedge clock); #1;
      n_cmp++; if ({load_error1, done1, ctrl_run1} !== 3'b110) begin n_bad++; $display("FAIL cor_sticky: got %b want 110", {load_error1, done1, ctrl_run1}); end
      corrupt_addr = -1;
   endtask

   task automatic test_reset_midload();
      logic [7:0] b [$];
      logic [7:0] b2 [$];
      int fa, r1, r0, bad;
      apply_reset();
      b = {8'($urandom), 8'($urandom)};
      send_stream(b, 0, 0, fa);
      for (int k = 0; k < 10 && !in_ready1; k++) begin @(posedge clock); #1; end
      in_valid = 1; in_data = 8'hC3; in_last = 0;
      @(posedge clock); #1;
      in_valid = 0;
      n_cmp++; if ({mem_clock1, mem_write1, load_count1} !== {2'b11, 9'd2}) begin n_bad++; $display("FAIL mid_wr_hi: clk/wr %b%b cnt %0d want 11 2", mem_clock1, mem_write1, load_count1); end
      reset_n = 0; #1;
      n_cmp++; if (mem_clock1 !== 1'b0 || mem_write1 !== 1'b0) begin n_bad++; $display("FAIL mid_strobe_cut: got %b%b want 00", mem_clock1, mem_write1); end
      n_cmp++; if (load_count1 !== 9'd0 || in_ready1 !== 1'b1) begin n_bad++; $display("FAIL mid_state: cnt %0d ready %b want 0 1", load_count1, in_ready1); end
      @(negedge clock); reset_n = 1;
      for (int i = 0; i < 3; i++) b2.push_back(8'($urandom));
      send_stream(b2, 1, 20, fa);
      wait_done(r1, r0);
      bad = 0;
      for (int i = 0; i < 3; i++) if (mem1[i] !== b2[i]) bad++;
      n_cmp++; if (bad != 0 || load_count1 !== 9'd3 || load_error1 !== 1'b0) begin n_bad++; $display("FAIL mid_reload: bad %0d cnt %0d err %b want 0 3 0", bad, load_count1, load_error1); end
   endtask

   task automatic test_run_mux();
      logic [7:0] a, d;
      logic c, w;
      #2;
      ctrl_addr = 8'h05; ctrl_mem_clock = 1; ctrl_mem_write = 0; ctrl_to_mem = 8'h3C; #1;
      n_cmp++; if (mem_addr1 !== 8'h05 || mem_clock1 !== 1'b1 || mem_write1 !== 1'b0) begin n_bad++; $display("FAIL run_dir: addr %h clk %b wr %b want 05 1 0", mem_addr1, mem_clock1, mem_write1); end
      n_cmp++; if (in_ready1 !== 1'b0) begin n_bad++; $display("FAIL run_ready: got %b want 0", in_ready1); end
      for (int i = 0; i < 4; i++) begin
         a = 8'($urandom); d = 8'($urandom); c = 1'($urandom); w = 1'($urandom);
         ctrl_addr = a; ctrl_to_mem = d; ctrl_mem_clock = c; ctrl_mem_write = w; #1;
         n_cmp++; if ({mem_addr1, mem_to1, mem_clock1, mem_write1} !== {a, d, c, w}) begin n_bad++; $display("FAIL run_rnd: got %h %h %b %b want %h %h %b %b", mem_addr1, mem_to1, mem_clock1, mem_write1, a, d, c, w); end
      end
      ctrl_mem_clock = 0; ctrl_mem_write = 0;
   endtask

   task automatic test_verify0_single();
      logic [7:0] b [$];
      int fa, r1, r0;
      apply_reset();
      b = {8'hA5};
      send_stream(b, 1, 0, fa);
      wait_done(r1, r0);
      n_cmp++; if (r0 - fa !== 3) begin n_bad++; $display("FAIL v0_latency: got %0d want 3", r0 - fa); end
      n_cmp++; if (r1 - fa !== 6) begin n_bad++; $display("FAIL v1_single_latency: got %0d want 6", r1 - fa); end
      n_cmp++; if (mem0[0] !== 8'hA5 || load_count0 !== 9'd1) begin n_bad++; $display("FAIL v0_mem: got %h cnt %0d want A5 1", mem0[0], load_count0); end
   endtask

   initial begin
      test_reset();
      test_directed4();
      test_random_gaps();
      test_full256();
      test_corrupt();
      test_reset_midload();
      test_run_mux();
      test_verify0_single();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
